// File: rtl/sd_dac_tx.sv
// rtl/sd_dac_tx.sv - first-order sigma-delta DAC transmitter with a one-entry sample buffer.
// Optional carry-in dither from a 16-bit LFSR when SD_DAC_DITHER_EN is defined.
module sd_dac_tx #(
  parameter int WIDTH = 8,
  parameter int OSR   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             clear_underrun,
  output logic             dac_out,
  output logic             frame_strobe,
  output logic             underrun
);

  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] OSR_LAST = CW'(OSR - 1);

  logic [WIDTH-1:0] buffer;
  logic             buf_full;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    osr_cnt;
  logic             boundary;
  logic             wr;
  logic             cin;
  logic [WIDTH:0]   sum;

  assign sample_ready = !buf_full;
  assign boundary     = enable && (osr_cnt == OSR_LAST);
  assign wr           = sample_valid && !buf_full;
  assign sum          = {1'b0, acc} + {1'b0, active} + {{WIDTH{1'b0}}, cin};

`ifdef SD_DAC_DITHER_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Taps 16,14,13,11 in 1-based numbering.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign cin     = lfsr[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (enable) begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end
`else
  assign cin = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer       <= '0;
      buf_full     <= 1'b0;
      active       <= '0;
      acc          <= '0;
      osr_cnt      <= '0;
      dac_out      <= 1'b0;
      frame_strobe <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      frame_strobe <= boundary && buf_full;

      // A full buffer blocks writes, so draining and writing never coincide.
      if (boundary && buf_full) begin
        active   <= buffer;
        buf_full <= 1'b0;
      end else if (wr) begin
        buffer   <= sample_in;
        buf_full <= 1'b1;
      end

      if (boundary && !buf_full) begin
        underrun <= 1'b1;
      end else if (clear_underrun) begin
        underrun <= 1'b0;
      end

      if (enable) begin
        osr_cnt <= (osr_cnt == OSR_LAST) ? '0 : osr_cnt + 1'b1;
        acc     <= sum[WIDTH-1:0];
        dac_out <= sum[WIDTH];
      end
    end
  end

endmodule
